// File: rtl/mem_arb_pkg.sv
// Shared constants and payload types for the DDR read arbiter.
package mem_arb_pkg;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_BEATS = 2;

  localparam int unsigned ADDR_W = 31;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CMD_W  = 3;

  // Requester identity, also the value stored in the tag queue.
  typedef enum logic {
    REQ_R0 = 1'b0,
    REQ_R1 = 1'b1
  } req_id_e;

  // One address FIFO entry.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CMD_W-1:0]  cmd;
  } af_req_t;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Requester, address FIFO and read data FIFO signals of the read arbiter.
interface mem_read_arbiter_if;
  import mem_arb_pkg::*;

  logic              r0_valid;
  logic [ADDR_W-1:0] r0_addr;
  logic              r0_ready;
  logic              r1_valid;
  logic [ADDR_W-1:0] r1_addr;
  logic              r1_ready;

  logic              af_wr_en;
  logic [ADDR_W-1:0] af_addr_din;
  logic [CMD_W-1:0]  af_cmd_din;
  logic              af_full;

  logic              rdf_valid;
  logic [DATA_W-1:0] rdf_dout;
  logic              rdf_rd_en;

  logic [DATA_W-1:0] rd_data;
  logic              r0_rd_valid;
  logic              r1_rd_valid;
  logic              idle;
  logic              err;

  // Arbiter side.
  modport slave (
    input  r0_valid, r0_addr, r1_valid, r1_addr, af_full, rdf_valid, rdf_dout,
    output r0_ready, r1_ready, af_wr_en, af_addr_din, af_cmd_din, rdf_rd_en,
           rd_data, r0_rd_valid, r1_rd_valid, idle, err
  );

  // Environment side: requesters and the two FIFOs.
  modport master (
    output r0_valid, r0_addr, r1_valid, r1_addr, af_full, rdf_valid, rdf_dout,
    input  r0_ready, r1_ready, af_wr_en, af_addr_din, af_cmd_din, rdf_rd_en,
           rd_data, r0_rd_valid, r1_rd_valid, idle, err
  );

endinterface

// File: rtl/mem_read_arbiter_tag_fifo.sv
// In-order 1-bit tag queue remembering which requester owns each outstanding read.
module tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     push_tag_i,
  input  logic                     pop_i,
  output logic                     head_tag_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Guarded push/pop and next pointer/occupancy values.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

  assign head_tag_o = mem_q[rd_ptr_q];
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter for two requesters sharing one DDR address FIFO;
// returned beats are routed back in request order via a tag queue.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned BEATS = DEF_BEATS
) (
  input  logic                clk,
  input  logic                rst,
  mem_read_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  logic              can_issue;
  logic              any_req;
  logic              push;
  req_id_e           grant_id;
  req_id_e           last_grant_q, last_grant_d;
  af_req_t           af_req;

  logic              beat_ok;
  logic              pop;
  logic              head_tag;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  occupancy;

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid0_q, rd_valid0_d;
  logic              rd_valid1_q, rd_valid1_d;
  logic              err_q, err_d;

  // Outstanding-request tag queue.
  tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_tag_i (1'(grant_id)),
    .pop_i      (pop),
    .head_tag_o (head_tag),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (occupancy)
  );

  // Combinational grant: the requester not served last wins a tie.
  always_comb begin
    can_issue = !rst && !bus.af_full && !fifo_full;
    any_req   = bus.r0_valid || bus.r1_valid;
    grant_id  = REQ_R0;
    if (bus.r1_valid && (!bus.r0_valid || last_grant_q == REQ_R0)) begin
      grant_id = REQ_R1;
    end
    push         = can_issue && any_req;
    last_grant_d = push ? grant_id : last_grant_q;
    af_req.addr  = (grant_id == REQ_R1) ? bus.r1_addr : bus.r0_addr;
    af_req.cmd   = CMD_READ;
  end

  // Beat routing: head tag selects the owner, final beat retires the tag.
  always_comb begin
    beat_ok     = bus.rdf_valid && !fifo_empty;
    pop         = beat_ok && (beat_cnt_q == BEAT_LAST);
    beat_cnt_d  = beat_cnt_q;
    rd_data_d   = rd_data_q;
    rd_valid0_d = 1'b0;
    rd_valid1_d = 1'b0;
    err_d       = err_q || (bus.rdf_valid && fifo_empty);
    if (beat_ok) begin
      rd_data_d   = bus.rdf_dout;
      rd_valid0_d = (head_tag == 1'(REQ_R0));
      rd_valid1_d = (head_tag == 1'(REQ_R1));
      beat_cnt_d  = pop ? '0 : beat_cnt_q + BEAT_W'(1);
    end
  end

  // State and returned-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_R1;
      beat_cnt_q   <= '0;
      rd_data_q    <= '0;
      rd_valid0_q  <= 1'b0;
      rd_valid1_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_data_q    <= rd_data_d;
      rd_valid0_q  <= rd_valid0_d;
      rd_valid1_q  <= rd_valid1_d;
      err_q        <= err_d;
    end
  end

  assign bus.r0_ready    = push && (grant_id == REQ_R0);
  assign bus.r1_ready    = push && (grant_id == REQ_R1);
  assign bus.af_wr_en    = push;
  assign bus.af_addr_din = af_req.addr;
  assign bus.af_cmd_din  = af_req.cmd;
  assign bus.rdf_rd_en   = 1'b1;
  assign bus.rd_data     = rd_data_q;
  assign bus.r0_rd_valid = rd_valid0_q;
  assign bus.r1_rd_valid = rd_valid1_q;
  assign bus.idle        = (occupancy == '0) && (beat_cnt_q == '0);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed and random checks of mem_read_arbiter against a queue-based model.
module tb_mem_read_arbiter;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned BEATS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_read_arbiter_if bus ();

  mem_read_arbiter #(
    .DEPTH (DEPTH),
    .BEATS (BEATS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: owners of outstanding reads in order, beats seen for the head.
  int           tagq[$];
  int           beats_seen = 0;
  int           last_win   = 1;
  bit           err_m      = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v0, input logic [30:0] a0, input bit v1,
                        input logic [30:0] a1, input bit full, input bit rv,
                        input logic [127:0] d);
    bus.r0_valid  = v0;
    bus.r0_addr   = a0;
    bus.r1_valid  = v1;
    bus.r1_addr   = a1;
    bus.af_full   = full;
    bus.rdf_valid = rv;
    bus.rdf_dout  = d;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: check the grant outputs, advance the model, check returned data.
  task automatic step();
    int          win;
    int          owner;
    bit          can;
    logic [30:0] exp_addr;
    logic [127:0] exp_data;
    #1;
    can = !bus.af_full && (tagq.size() < DEPTH);
    win = -1;
    if (bus.r0_valid && bus.r1_valid) win = (last_win == 1) ? 0 : 1;
    else if (bus.r0_valid)            win = 0;
    else if (bus.r1_valid)            win = 1;
    if (!can) win = -1;
    chk("r0_ready", bus.r0_ready, (win == 0));
    chk("r1_ready", bus.r1_ready, (win == 1));
    chk("af_wr_en", bus.af_wr_en, (win >= 0));
    chk("rdf_rd_en", bus.rdf_rd_en, 1'b1);
    if (win >= 0) begin
      exp_addr = (win == 1) ? bus.r1_addr : bus.r0_addr;
      chk("af_addr_din", bus.af_addr_din, exp_addr);
      chk("af_cmd_din", bus.af_cmd_din, 3'b001);
    end
    owner    = -1;
    exp_data = '0;
    if (bus.rdf_valid) begin
      if (tagq.size() > 0) begin
        owner    = tagq[0];
        exp_data = bus.rdf_dout;
        beats_seen++;
        if (beats_seen == BEATS) begin
          void'(tagq.pop_front());
          beats_seen = 0;
        end
      end else begin
        err_m = 1'b1;
      end
    end
    if (win >= 0) begin
      tagq.push_back(win);
      last_win = win;
    end
    @(posedge clk);
    #1;
    chk("r0_rd_valid", bus.r0_rd_valid, (owner == 0));
    chk("r1_rd_valid", bus.r1_rd_valid, (owner == 1));
    if (owner >= 0) chk("rd_data", bus.rd_data, exp_data);
    chk("idle", bus.idle, (tagq.size() == 0 && beats_seen == 0));
    chk("err", bus.err, err_m);
    @(negedge clk);
  endtask

  // Reset for one clock while whatever inputs are present stay applied.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_r0_ready", bus.r0_ready, 1'b0);
    chk("rst_r1_ready", bus.r1_ready, 1'b0);
    chk("rst_af_wr_en", bus.af_wr_en, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_r0_rd_valid", bus.r0_rd_valid, 1'b0);
    chk("rst_r1_rd_valid", bus.r1_rd_valid, 1'b0);
    chk("rst_rd_data", bus.rd_data, 128'h0);
    chk("rst_idle", bus.idle, 1'b1);
    chk("rst_err", bus.err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tagq.delete();
    beats_seen = 0;
    last_win   = 1;
    err_m      = 1'b0;
  endtask

  // Return beats until the model has nothing outstanding (bounded).
  task automatic drain();
    for (int n = 0; n < 4 * DEPTH * BEATS && tagq.size() > 0; n++) begin
      set_in(0, '0, 0, '0, 0, 1, rnd128());
      step();
    end
    set_in(0, '0, 0, '0, 0, 0, '0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    set_in(1, 31'h1, 1, 31'h2, 0, 0, '0);
    @(negedge clk);
    do_reset();

    // Single r0 read, two beats back.
    set_in(1, 31'h0000100, 0, '0, 0, 0, '0);
    step();
    set_in(0, '0, 0, '0, 0, 0, '0);
    step();
    set_in(0, '0, 0, '0, 0, 1, 128'hAAAA_0000_1111_2222_3333_4444_5555_6666);
    step();
    set_in(0, '0, 0, '0, 0, 1, 128'hBBBB_7777_8888_9999_CCCC_DDDD_EEEE_FFFF);
    step();
    set_in(0, '0, 0, '0, 0, 0, '0);
    step();

    // Both requesters held for six cycles, then twelve beats.
    set_in(0, '0, 0, '0, 0, 0, '0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1, 31'(32'h1000 + i), 1, 31'(32'h2000 + i), 0, 0, '0);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      set_in(0, '0, 0, '0, 0, 1, rnd128());
      step();
    end

    // Fill to DEPTH, one refused request, then one full return frees a slot.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 31'(32'h300 + i), 0, '0, 0, 0, '0);
      step();
    end
    set_in(1, 31'h400, 1, 31'h500, 0, 0, '0);
    step();
    for (int i = 0; i < BEATS; i++) begin
      set_in(1, 31'h400, 1, 31'h500, 0, 1, rnd128());
      step();
    end
    set_in(1, 31'h400, 1, 31'h500, 0, 0, '0);
    step();
    drain();

    // Address FIFO full with both requesting, then released.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 31'h600, 1, 31'h700, 1, 0, '0);
      step();
    end
    set_in(1, 31'h600, 1, 31'h700, 0, 0, '0);
    step();
    set_in(1, 31'h610, 1, 31'h710, 0, 0, '0);
    step();
    drain();

    // Push coinciding with a final beat at occupancy three.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, '0, 1, 31'(32'h800 + i), 0, 0, '0);
      step();
    end
    set_in(0, '0, 0, '0, 0, 1, rnd128());
    step();
    set_in(1, 31'h900, 0, '0, 0, 1, rnd128());
    step();
    drain();

    // Reset with four outstanding, then a stray beat.
    for (int i = 0; i < 4; i++) begin
      set_in(i[0], 31'(32'hA00 + i), !i[0], 31'(32'hB00 + i), 0, 0, '0);
      step();
    end
    set_in(1, 31'hC00, 1, 31'hD00, 0, 0, '0);
    do_reset();
    set_in(0, '0, 0, '0, 0, 1, rnd128());
    step();
    set_in(0, '0, 0, '0, 0, 0, '0);
    step();

    // Random traffic against the model, with one reset in the middle.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        set_in(1, 31'($urandom), 1, 31'($urandom), 0, 0, '0);
        do_reset();
      end
      set_in(($urandom_range(0, 1) == 1), 31'($urandom),
             ($urandom_range(0, 1) == 1), 31'($urandom),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 9) < 4), rnd128());
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter DEPTH, default 8: max outstanding read requests; power of two, 2..16.
REQ-002 Parameter BEATS, default 2: rdf beats returned per read request.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 r0_valid  input  1  requester 0 (pixel feeder) read request valid.
REQ-006 r0_addr  input  31  requester 0 DDR address.
REQ-007 r0_ready  output  1  requester 0 request accepted this cycle when r0_valid also high.
REQ-008 r1_valid / r1_addr / r1_ready  in / in / out  1 / 31 / 1  same, requester 1 (GP fetch).
REQ-009 af_wr_en  output  1  address FIFO push.
REQ-010 af_addr_din  output  31  address FIFO data.
REQ-011 af_cmd_din  output  3  address FIFO command.
REQ-012 af_full  input  1  address FIFO full.
REQ-013 rdf_valid  input  1  read data FIFO beat available.
REQ-014 rdf_dout  input  128  read data beat.
REQ-015 rdf_rd_en  output  1  read data FIFO pop.
REQ-016 rd_data  output  128  registered returned beat, shared by both requesters.
REQ-017 r0_rd_valid / r1_rd_valid  output  1 each  rd_data belongs to that requester this cycle.
REQ-018 idle  output  1  no outstanding requests.
REQ-019 err  output  1  sticky: rdf_valid seen with no outstanding request.

Function
REQ-020 can_issue = !af_full & (outstanding < DEPTH); r0_ready/r1_ready SHALL be low when can_issue is low.
REQ-021 One request max per cycle; r0 only valid -> r0 granted; r1 only valid -> r1 granted; both valid -> the requester not granted last SHALL win (round-robin; last_grant resets to r1, so r0 wins the first tie).
REQ-022 Grant is combinational: rN_ready = can_issue & grantN; same cycle af_wr_en=1, af_addr_din=rN_addr, af_cmd_din=3'b001 (read).
REQ-023 af_wr_en SHALL be 0 whenever no handshake completes; af_addr_din/af_cmd_din don't-care then.
REQ-024 last_grant updates only on a completed handshake.
REQ-025 Each accepted request pushes its requester ID into an in-order tag queue (DEPTH entries, 1 bit); outstanding count = queue occupancy.
REQ-026 rdf_rd_en SHALL be held at 1 always.
REQ-027 On rdf_valid with queue non-empty: next cycle rd_data=rdf_dout and r<head>_rd_valid=1 (latency exactly 1 cycle); beat counter increments.
REQ-028 On the BEATS-th beat, beat counter wraps to 0 and the head tag is popped that same cycle.
REQ-029 Push and pop in the same cycle SHALL leave occupancy unchanged; push when occupancy == DEPTH is impossible (REQ-020).
REQ-030 rdf_valid with queue empty: beat discarded, no rd_valid, err set until reset.
REQ-031 r0_rd_valid and r1_rd_valid SHALL never both be high.
REQ-032 idle = (occupancy == 0) & (beat counter == 0).
REQ-033 Requester valid dropping without handshake SHALL have no effect on state.

Reset
REQ-034 On rst: tag queue empty, beat counter 0, last_grant=r1, err=0, r0_rd_valid=r1_rd_valid=0, rd_data=0, idle=1; af_wr_en=0 and rN_ready=0 during rst.
REQ-035 rst mid-operation SHALL drop all outstanding tags; beats arriving after reset are treated per REQ-030.

Structure
REQ-036 Package mem_arb_pkg SHALL hold CMD_READ=3'b001, CMD_WRITE=3'b000, default DEPTH and BEATS.
REQ-037 Tag queue SHALL be a separate sub-module tag_fifo (1-bit wide, parameterised depth, push/pop/full/empty/count); arbitration and beat routing stay in mem_read_arbiter.

Verification
REQ-038 r0 alone issues addr 0x0000100 -> same cycle af_wr_en=1, af_addr_din=0x0000100, af_cmd_din=001; two rdf beats A,B -> r0_rd_valid with A then B, each 1 cycle after rdf_valid; idle=1 after.
REQ-039 r0 and r1 held valid 6 cycles, af_full=0, data withheld -> grants r0,r1,r0,r1,r0,r1; then 12 beats return routed r0,r0,r1,r1,... in order.
REQ-040 8 requests accepted, no data -> r0_ready=r1_ready=0 on 9th; one full return (2 beats) -> next request accepted the cycle after pop.
REQ-041 af_full=1 for 3 cycles with both valid -> no af_wr_en, no ready, last_grant unchanged; af_full drops -> correct RR winner.
REQ-042 Handshake and final beat in same cycle at occupancy 8 case excluded; at occupancy 3 -> occupancy stays 3.
REQ-043 rst asserted with 4 outstanding, then rdf_valid -> no rd_valid, err=1, idle=1.
